// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divider math.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side byte handshake: data/ready/ack plus status pulses.
interface uart_rx_oversample_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 rx_ack;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_ready, rx_busy, frame_err, overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_ready, rx_busy, frame_err, overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a 1-clk tick every DIV clocks; sync clear restarts the period.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);
endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-flop sync, start-glitch reject, 3-sample mid-bit vote,
// framing-error and overrun detection, byte delivery via rx_data/rx_ready/rx_ack.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  uart_rx_oversample_if.master  rx_if
);
  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  uart_state_t          state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [SW-1:0]        s;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp_a, smp_b;
  logic                 stop_err;
  logic                 tick;
  logic                 start_edge, vote, at_vote, at_wrap;

  assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
  assign vote       = maj3(smp_a, smp_b, rx_sync);
  assign at_vote    = tick && (s == S_VOTE);
  assign at_wrap    = tick && (s == S_LAST);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_edge),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rx_meta         <= 1'b1;
      rx_sync         <= 1'b1;
      rx_prev         <= 1'b1;
      s               <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      smp_a           <= 1'b1;
      smp_b           <= 1'b1;
      stop_err        <= 1'b0;
      rx_if.rx_data   <= '0;
      rx_if.rx_ready  <= 1'b0;
      rx_if.rx_busy   <= 1'b0;
      rx_if.frame_err <= 1'b0;
      rx_if.overrun   <= 1'b0;
    end else begin
      rx_meta         <= rx;
      rx_sync         <= rx_meta;
      rx_prev         <= rx_sync;
      rx_if.frame_err <= 1'b0;
      rx_if.overrun   <= 1'b0;

      if (rx_if.rx_ack && rx_if.rx_ready) rx_if.rx_ready <= 1'b0;

      if (state != IDLE && tick) begin
        s <= (s == S_LAST) ? '0 : s + SW'(1);
        if (s == S_A) smp_a <= rx_sync;
        if (s == S_B) smp_b <= rx_sync;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state         <= START;
            rx_if.rx_busy <= 1'b1;
            s             <= '0;
            bit_cnt       <= '0;
            stop_err      <= 1'b0;
          end
        end
        START: begin
          if (at_vote && vote) begin
            state         <= IDLE;
            rx_if.rx_busy <= 1'b0;
          end else if (at_wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_vote) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (at_wrap && bit_cnt == 4'(DATA_BITS)) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          // Leaving at the last vote (mid-stop-bit) keeps the next start edge visible.
          if (at_vote) begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state         <= IDLE;
              rx_if.rx_busy <= 1'b0;
              if (stop_err || !vote) begin
                rx_if.frame_err <= 1'b1;
              end else if (!rx_if.rx_ready || rx_if.rx_ack) begin
                rx_if.rx_data  <= shreg;
                rx_if.rx_ready <= 1'b1;
              end else begin
                rx_if.overrun <= 1'b1;
              end
            end else begin
              stop_err <= stop_err | ~vote;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          rx_if.rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample at default parameters (432 clk per bit).
module tb_uart_rx_oversample;
  localparam int BIT_CLK = 432;

  typedef enum int {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  uart_rx_oversample_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_oversample #(
    .CLK_FREQ   (50000000),
    .BAUD_RATE  (115200),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_if (rx_if.master)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_event(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%02h, want nothing", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_DATA && e.data !== data)) begin
        n_fail++;
        $display("FAIL event: got kind %0d data 0x%02h, want kind %0d data 0x%02h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every delivery (ready rise or new byte under held ready) and status pulse
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (rx_if.frame_err) expect_event(EV_FERR, 8'h00);
      if (rx_if.overrun)   expect_event(EV_OVR, 8'h00);
      if (rx_if.rx_ready && (!prev_ready || rx_if.rx_data != prev_data))
        expect_event(EV_DATA, rx_if.rx_data);
    end
    prev_ready = rx_if.rx_ready;
    prev_data  = rx_if.rx_data;
  end

  task automatic send_byte(input logic [7:0] b, input int bit_clk, input logic stop_val);
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clk) @(negedge clk);
    end
    rx = stop_val;
    repeat (bit_clk) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int max_clk);
    int w;
    w = 0;
    while (!rx_if.rx_ready && w < max_clk) begin
      @(negedge clk);
      w++;
    end
    check(name, rx_if.rx_ready, 1);
  endtask

  task automatic ack_pulse();
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         w;
    logic [7:0] pat [3];
    int         rates [2];
    logic [7:0] part;

    pat   = '{8'hFF, 8'h00, 8'hC3};
    rates = '{423, 441};
    part  = 8'h99;

    rst_n = 1'b0;
    rx    = 1'b1;
    rx_if.rx_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data",   rx_if.rx_data,   0);
    check("reset_rx_ready",  rx_if.rx_ready,  0);
    check("reset_rx_busy",   rx_if.rx_busy,   0);
    check("reset_frame_err", rx_if.frame_err, 0);
    check("reset_overrun",   rx_if.overrun,   0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", rx_if.rx_busy, 0);

    // 0xA5, ack 10 clk after ready
    exp_q.push_back('{EV_DATA, 8'hA5});
    fork
      send_byte(8'hA5, BIT_CLK, 1'b1);
      begin
        wait_ready("a5_ready", 6000);
        repeat (10) @(negedge clk);
        check("a5_held",  rx_if.rx_ready, 1);
        check("a5_data",  rx_if.rx_data,  32'hA5);
        ack_pulse();
        check("a5_ack_clear", rx_if.rx_ready, 0);
      end
    join

    // 100-clk low glitch
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy", rx_if.rx_busy, 1);
    repeat (80) @(negedge clk);
    rx = 1'b1;
    w = 0;
    while (rx_if.rx_busy && w < BIT_CLK - 100) begin
      @(negedge clk);
      w++;
    end
    check("glitch_busy_drop", rx_if.rx_busy, 0);
    repeat (600) @(negedge clk);
    check("glitch_no_ready", rx_if.rx_ready, 0);

    // 0x55 with stop bit forced low
    exp_q.push_back('{EV_FERR, 8'h00});
    send_byte(8'h55, BIT_CLK, 1'b0);
    repeat (50) @(negedge clk);
    check("ferr_no_ready", rx_if.rx_ready, 0);
    check("ferr_data_kept", rx_if.rx_data, 32'hA5);

    // 0x12 then 0x34, no ack: overrun, first byte kept
    exp_q.push_back('{EV_DATA, 8'h12});
    exp_q.push_back('{EV_OVR, 8'h00});
    send_byte(8'h12, BIT_CLK, 1'b1);
    send_byte(8'h34, BIT_CLK, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_data_kept", rx_if.rx_data,  32'h12);
    check("ovr_ready",     rx_if.rx_ready, 1);
    ack_pulse();
    check("ovr_ack_clear", rx_if.rx_ready, 0);

    // ack in the exact completion cycle of the second frame
    exp_q.push_back('{EV_DATA, 8'h12});
    k = 0;
    fork
      send_byte(8'h12, BIT_CLK, 1'b1);
      begin
        while (!rx_if.rx_ready && k < 6000) begin
          @(negedge clk);
          k++;
        end
      end
    join
    check("same_first_ready", rx_if.rx_ready, 1);
    exp_q.push_back('{EV_DATA, 8'h34});
    fork
      send_byte(8'h34, BIT_CLK, 1'b1);
      begin
        repeat (k - 1) @(negedge clk);
        rx_if.rx_ack = 1'b1;
        @(negedge clk);
        rx_if.rx_ack = 1'b0;
      end
    join
    check("same_ready", rx_if.rx_ready, 1);
    check("same_data",  rx_if.rx_data,  32'h34);
    ack_pulse();
    check("same_ack_clear", rx_if.rx_ready, 0);

    // baud tolerance, back-to-back frames at -2% / +2%
    foreach (rates[r]) begin
      foreach (pat[p]) begin
        exp_q.push_back('{EV_DATA, pat[p]});
        fork
          send_byte(pat[p], rates[r], 1'b1);
          begin
            wait_ready("tol_ready", 6000);
            ack_pulse();
          end
        join
      end
    end

    // reset mid-frame with a byte pending, then a clean frame
    exp_q.push_back('{EV_DATA, 8'h5A});
    fork
      send_byte(8'h5A, BIT_CLK, 1'b1);
      wait_ready("pre_rst_ready", 6000);
    join
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      repeat ((i == 3) ? BIT_CLK / 2 : BIT_CLK) @(negedge clk);
    end
    check("mid_frame_busy", rx_if.rx_busy, 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("rst_rx_ready", rx_if.rx_ready, 0);
    check("rst_rx_data",  rx_if.rx_data,  0);
    check("rst_rx_busy",  rx_if.rx_busy,  0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_idle", rx_if.rx_busy, 0);
    exp_q.push_back('{EV_DATA, 8'h3C});
    fork
      send_byte(8'h3C, BIT_CLK, 1'b1);
      begin
        wait_ready("post_rst_ready", 6000);
        check("post_rst_data", rx_if.rx_data, 32'h3C);
        ack_pulse();
      end
    join

    repeat (100) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
